// File: rtl/perf_sampler_pkg.sv
// Shared types and defaults for the performance counter sampler.
// The sweep FSM state encoding and the tagged sample record live here.
package perf_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ_LO = 2'd1,
      READ_HI = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0]  idx;
      logic [7:0]  seq;
      logic        last;
      logic [63:0] data;
   } sample_t;

   localparam logic [11:0] CNT_BASE_ADDR   = 12'hB03;
   localparam logic [11:0] CNT_BASE_ADDR_H = 12'hB83;

endpackage

// File: rtl/perf_sample_fifo.sv
// First-word-fall-through FIFO for tagged samples; head is read straight from storage.
// Push while full is dropped here, so the producer must check full before pushing.
module perf_sample_fifo #(
   parameter type T     = logic [7:0],
   parameter int  Depth = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(Depth);

   T               mem [Depth];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           wr_en;
   logic           rd_en;

   assign full  = (count == (AW+1)'(Depth));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; occupancy is tracked by count, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/perf_counter_sampler.sv
// Periodic sweep of selected mhpmcounters through the shared read port into a sample FIFO.
// The read port is only used in cycles the CSR regfile leaves free.
module perf_counter_sampler
   import perf_sampler_pkg::*;
#(
   parameter int          XLEN         = 64,
   parameter int          NumCounters  = 6,
   parameter int          FifoDepth    = 4,
   parameter int          PeriodWidth  = 32,
   parameter logic [11:0] CntBaseAddr  = CNT_BASE_ADDR,
   parameter logic [11:0] CntBaseAddrH = CNT_BASE_ADDR_H
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic [PeriodWidth-1:0] period_i,
   input  logic [NumCounters-1:0] counter_mask_i,
   input  logic                   csr_busy_i,
   output logic                   pc_req_o,
   output logic [11:0]            pc_addr_o,
   input  logic [XLEN-1:0]        pc_data_i,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic [2:0]             sample_idx_o,
   output logic [7:0]             sample_seq_o,
   output logic                   sample_last_o,
   output logic [63:0]            sample_data_o,
   output logic [15:0]            dropped_o,
   output logic                   busy_o
);

   logic [PeriodWidth-1:0] timer_q;
   state_t                 state_q;
   logic [NumCounters-1:0] mask_q;
   logic [2:0]             idx_q;
   logic [7:0]             seq_q;
   logic [31:0]            lo_q;
   logic [15:0]            dropped_q;

   logic       trigger;
   logic [2:0] first_idx;
   logic [2:0] next_idx;
   logic       has_next;
   logic       reading;
   logic       push;
   logic [63:0] rd_data;
   sample_t    push_sample;
   sample_t    head;
   logic       fifo_full;
   logic       fifo_empty;

   assign trigger = enable_i && (period_i != '0) && (timer_q == PeriodWidth'(1));

   // Timer value 0 while enabled only occurs right after reset or a period change; it just reloads.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q <= '0;
      end else if (!enable_i || (period_i == '0) || (timer_q <= PeriodWidth'(1))) begin
         timer_q <= period_i;
      end else begin
         timer_q <= timer_q - PeriodWidth'(1);
      end
   end

   // NOTE: every variable gets a default first so the priority loops cannot infer latches.
   always_comb begin
      first_idx = '0;
      next_idx  = idx_q;
      has_next  = 1'b0;
      for (int k = NumCounters - 1; k >= 0; k--) begin
         if (counter_mask_i[k]) first_idx = 3'(k);
         if (mask_q[k] && (3'(k) > idx_q)) begin
            next_idx = 3'(k);
            has_next = 1'b1;
         end
      end
   end

   assign reading  = (state_q == READ_LO) || (state_q == READ_HI);
   assign pc_req_o = reading && !csr_busy_i && !fifo_full;
   assign rd_data  = 64'(pc_data_i);
   assign push     = pc_req_o && ((state_q == READ_HI) || (XLEN == 64));

   always_comb begin
      pc_addr_o = '0;
      if (pc_req_o) begin
         pc_addr_o = ((state_q == READ_HI) ? CntBaseAddrH : CntBaseAddr) + 12'(idx_q);
      end
   end

   always_comb begin
      push_sample.idx  = idx_q;
      push_sample.seq  = seq_q;
      push_sample.last = !has_next;
      push_sample.data = (XLEN == 32) ? {rd_data[31:0], lo_q} : rd_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         idx_q     <= '0;
         seq_q     <= '0;
         lo_q      <= '0;
         dropped_q <= '0;
      end else begin
         if (trigger && (state_q != IDLE) && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
         end
         case (state_q)
            IDLE: begin
               if (trigger && (counter_mask_i != '0)) begin
                  mask_q  <= counter_mask_i;
                  idx_q   <= first_idx;
                  state_q <= READ_LO;
               end
            end
            READ_LO: begin
               if (pc_req_o && (XLEN == 32)) begin
                  lo_q    <= rd_data[31:0];
                  state_q <= READ_HI;
               end
            end
            READ_HI: ;
            default: state_q <= IDLE;
         endcase
         // Completing a sample advances the sweep; this overrides the per-state holds above.
         if (push) begin
            if (!has_next) begin
               seq_q   <= seq_q + 8'd1;
               state_q <= IDLE;
            end else begin
               idx_q   <= next_idx;
               state_q <= READ_LO;
            end
         end
      end
   end

   perf_sample_fifo #(
      .T     (sample_t),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (push_sample),
      .pop       (sample_valid_o && sample_ready_i),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign sample_valid_o = !fifo_empty;
   assign sample_idx_o   = fifo_empty ? 3'd0  : head.idx;
   assign sample_seq_o   = fifo_empty ? 8'd0  : head.seq;
   assign sample_last_o  = fifo_empty ? 1'b0  : head.last;
   assign sample_data_o  = fifo_empty ? 64'd0 : head.data;
   assign dropped_o      = dropped_q;
   assign busy_o         = (state_q != IDLE);

endmodule
